// File: rtl/keypad_scan_ctrl.sv
//==============================================================================
// keypad_scan_ctrl : 3x4 matrix keypad scanner with debounce and key-code FIFO
// Revision: 1.0
//==============================================================================
`default_nettype none

module keypad_scan_ctrl #(
    parameter int TICK_DIV   = 1325000,
    parameter int DB_TICKS   = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          B,
    input  logic                          G,
    input  logic                          F,
    input  logic                          D,
    output logic                          C,
    output logic                          A,
    output logic                          E,
    input  logic                          KEY_ACK,
    output logic [3:0]                    KEY_DATA,
    output logic                          INTR,
    output logic [$clog2(FIFO_DEPTH):0]   COUNT,
    output logic                          OVF
);

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(DB_TICKS + 1);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HELD     = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Scan tick generator
    // ------------------------------------------------------------------
    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Row synchronizer and hit decode
    // ------------------------------------------------------------------
    logic [3:0] row_meta;
    logic [3:0] row_sync;
    logic       hit;
    logic [1:0] hit_idx;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            row_meta <= '0;
            row_sync <= '0;
        end else begin
            row_meta <= {D, F, G, B};
            row_sync <= row_meta;
        end
    end

    always_comb begin
        hit     = 1'b1;
        hit_idx = 2'd0;
        case (row_sync)
            4'b0001: hit_idx = 2'd0;
            4'b0010: hit_idx = 2'd1;
            4'b0100: hit_idx = 2'd2;
            4'b1000: hit_idx = 2'd3;
            default: hit     = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Scan / debounce FSM
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic [1:0]    row_q, row_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push;
    logic [1:0]    col_next;
    logic          same_sole;
    logic          latched_hi;
    logic [3:0]    code;

    assign col_next   = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
    assign same_sole  = hit && (hit_idx == row_q);
    assign latched_hi = row_sync[row_q];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_SCAN;
            col_q   <= 2'd0;
            row_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        if (tick) begin
            case (state_q)
                S_SCAN: begin
                    if (hit) begin
                        row_d = hit_idx;
                        cnt_d = CW'(1);
                        // A single-tick debounce completes on the detecting tick.
                        if (DB_TICKS == 1) begin
                            push    = 1'b1;
                            state_d = S_HELD;
                        end else begin
                            state_d = S_DEBOUNCE;
                        end
                    end else begin
                        col_d = col_next;
                    end
                end
                S_DEBOUNCE: begin
                    if (same_sole) begin
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_d == CW'(DB_TICKS)) begin
                            push    = 1'b1;
                            state_d = S_HELD;
                        end
                    end else begin
                        state_d = S_SCAN;
                    end
                end
                S_HELD: begin
                    if (!latched_hi) begin
                        cnt_d = CW'(1);
                        if (DB_TICKS == 1) begin
                            state_d = S_SCAN;
                            col_d   = col_next;
                        end else begin
                            state_d = S_RELEASE;
                        end
                    end
                end
                S_RELEASE: begin
                    if (!latched_hi) begin
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_d == CW'(DB_TICKS)) begin
                            state_d = S_SCAN;
                            col_d   = col_next;
                        end
                    end else begin
                        state_d = S_HELD;
                    end
                end
                default: state_d = S_SCAN;
            endcase
        end
    end

    // Row 4 carries the *, 0, # keys; rows 1-3 are the digits 1-9.
    always_comb begin
        code = 4'd0;
        if (row_d == 2'd3) begin
            case (col_q)
                2'd0:    code = 4'hA;
                2'd1:    code = 4'h0;
                default: code = 4'hB;
            endcase
        end else begin
            code = 4'({2'b00, row_d}) * 4'd3 + 4'({2'b00, col_q}) + 4'd1;
        end
    end

    assign C = (col_q == 2'd0);
    assign A = (col_q == 2'd1);
    assign E = (col_q == 2'd2);

    // ------------------------------------------------------------------
    // Key-code FIFO
    // ------------------------------------------------------------------
    logic [3:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          ovf_q;
    logic          full;
    logic          pop;
    logic          wr_en;
    logic          drop;

    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign pop   = KEY_ACK && (count != '0);
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr] <= code;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (pop) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign COUNT    = count;
    assign INTR     = (count != '0);
    assign KEY_DATA = INTR ? mem[rd_ptr] : 4'd0;
    assign OVF      = ovf_q;

endmodule

`default_nettype wire

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 1325000, CLK cycles per scan tick (>=2).
REQ-002 Parameter DB_TICKS, default 3, consecutive stable ticks required for press and for release (>=1).
REQ-003 Parameter FIFO_DEPTH, default 4, key-code buffer depth (power of 2).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 CLK  in  1  system clock; all state on rising edge.
REQ-006 RST_N  in  1  asynchronous active-low reset.
REQ-007 B, G, F, D  in  1 each  keypad rows 1-4, active-high, asynchronous to CLK.
REQ-008 C, A, E  out  1 each  keypad column drives for columns 1-3, one-hot active-high.
REQ-009 KEY_ACK  in  1  one-CLK pulse from the CPU, pops the FIFO head.
REQ-010 KEY_DATA  out  4  FIFO head key code; 0 when empty.
REQ-011 INTR  out  1  interrupt request, high while FIFO non-empty.
REQ-012 COUNT  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-013 OVF  out  1  sticky overflow flag.

Function
REQ-014 Tick generator: a counter SHALL emit a one-CLK tick every TICK_DIV CLK cycles; all scan/debounce state SHALL advance only on tick cycles.
REQ-015 Rows SHALL pass through a 2-flop synchronizer before use; row vector R = {D,F,G,B} after sync.
REQ-016 Valid hit: exactly one bit of R high; zero or multiple rows high SHALL be treated as no hit.
REQ-017 Key code for row r (1-4) and column c (1-3): rows 1-3 -> 3*(r-1)+c; row 4: col1 -> 0xA (*), col2 -> 0x0, col3 -> 0xB (#).
REQ-018 FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
REQ-019 SCAN: on tick with no valid hit, column SHALL rotate C->A->E->C; on tick with valid hit, latch row index, hold column, load debounce count 1, go DEBOUNCE.
REQ-020 DEBOUNCE: on tick, same row still sole hit -> increment count; count reaching DB_TICKS -> push code, go HELD; any other R -> return SCAN, column unchanged.
REQ-021 HELD: column held; on tick with latched row low -> load release count 1, go RELEASE; no further push while held (no auto-repeat).
REQ-022 RELEASE: on tick, latched row low -> increment; reaching DB_TICKS -> SCAN with next column; latched row high -> back to HELD.
REQ-023 Push SHALL occur on the CLK edge ending the completing tick cycle; COUNT, KEY_DATA, INTR SHALL reflect it in the following cycle (INTR decoded from registered COUNT, no extra latency).
REQ-024 KEY_ACK with COUNT>0 SHALL pop one entry on that edge; KEY_ACK with COUNT=0 SHALL be ignored.
REQ-025 Push when full and no pop: code dropped, contents unchanged, OVF set.
REQ-026 Simultaneous push and pop: when full both occur, COUNT unchanged, OVF not set; when empty only push occurs.
REQ-027 OVF SHALL clear on the next accepted KEY_ACK pop unless a dropped push occurs the same cycle.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-029 RST_N low SHALL immediately force: state SCAN, column C=1 A=0 E=0, tick and debounce counters 0, synchronizers 0, FIFO empty, COUNT=0, KEY_DATA=0, INTR=0, OVF=0.
REQ-030 Reset asserted mid-debounce or mid-hold SHALL discard the pending key with no push; scanning resumes at column C on the first tick after release.

Verification (TICK_DIV=4, DB_TICKS=3, FIFO_DEPTH=4)
REQ-031 Hold G high only while A driven, >=5 ticks -> single push of 0x5, INTR=1, COUNT=1, KEY_DATA=0x5; no second push while held.
REQ-032 Row F pulse lasting 2 ticks during column E -> no push, FSM back in SCAN, INTR stays 0.
REQ-033 Press/release keys 1, 0, #, 9, 7 with no KEY_ACK -> COUNT=4, KEY_DATA=0x1, OVF=1 after fifth; one KEY_ACK -> KEY_DATA=0x0, COUNT=3, OVF=0.
REQ-034 FIFO full and KEY_ACK in the push cycle -> COUNT stays 4, OVF=0, newest code at tail.
REQ-035 RST_N pulsed low during DEBOUNCE of key 3 -> all outputs at reset values, no push after release.
REQ-036 KEY_ACK while empty -> COUNT=0, KEY_DATA=0, INTR=0, no pointer change.
